// File: rtl/sauria_buf_ctrl.sv
// Ping-pong buffer controller: tracks host fill and core processing of
// NUM_BUF SRAM buffer sets, launches core jobs and reports completion/errors.
module sauria_buf_ctrl #(
    parameter int NUM_BUF = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0,
    localparam int SEL_W  = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_host_done,
    output logic             o_host_ready,
    output logic [SEL_W-1:0] o_host_sel,
    input  logic             i_core_en,
    output logic             o_core_start,
    output logic [SEL_W-1:0] o_core_sel,
    input  logic             i_core_done,
    input  logic             i_intr_clr,
    input  logic             i_err_clr,
    output logic             o_doneintr,
    output logic [1:0]       o_err,
    output logic [SEL_W:0]   o_occ,
    output logic [CNT_W-1:0] o_job_cnt
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [SEL_W:0] OCC_FULL = (SEL_W + 1)'(NUM_BUF);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_BUF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] fill_q, fill_d;
    logic [SEL_W-1:0] proc_q, proc_d;
    logic [SEL_W:0]   occ_q, occ_d;
    logic [SEL_W:0]   pend;
    logic [TMO_W-1:0] run_q, run_d;
    logic             intr_q, intr_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic reject;
    logic rel_ok;
    logic rel_tmo;
    logic rel_any;
    logic stray_done;
    logic tmo_hit;

    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign o_host_ready = (occ_q < OCC_FULL);
    assign o_host_sel   = fill_q;
    assign o_core_sel   = proc_q;
    assign o_core_start = (state_q == ST_START);
    assign o_doneintr   = intr_q;
    assign o_err        = err_q;
    assign o_occ        = occ_q;
    assign o_job_cnt    = cnt_q;

    assign accept  = i_host_done && o_host_ready;
    assign reject  = i_host_done && !o_host_ready;
    assign pend    = (state_q == ST_IDLE) ? occ_q : occ_q - 1'b1;
    assign tmo_hit = (TIMEOUT != 0) && (run_q == TMO_LAST);
    assign rel_any = rel_ok || rel_tmo;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        rel_ok     = 1'b0;
        rel_tmo    = 1'b0;
        stray_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                stray_done = i_core_done;
                if (i_core_en && (pend != '0)) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                stray_done = i_core_done;
                state_d    = ST_RUN;
                run_d      = '0;
            end
            ST_RUN: begin
                // a real completion wins over a watchdog hit in the same cycle
                if (i_core_done) begin
                    rel_ok = 1'b1;
                end else if (tmo_hit) begin
                    rel_tmo = 1'b1;
                end else if (TIMEOUT != 0) begin
                    run_d = run_q + 1'b1;
                end
                if (i_core_done || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        unique case ({accept, rel_any})
            2'b10: occ_d = occ_q + 1'b1;
            2'b01: begin
                if (occ_q != '0) begin
                    occ_d = occ_q - 1'b1;
                end
            end
            default: occ_d = occ_q;
        endcase
        fill_d = accept ? ptr_inc(fill_q) : fill_q;
        proc_d = rel_any ? ptr_inc(proc_q) : proc_q;
        cnt_d  = rel_ok ? cnt_q + 1'b1 : cnt_q;
    end

    // sticky flags: a set in the same cycle as a clear takes priority
    always_comb begin
        intr_d = intr_q;
        err_d  = err_q;
        if (rel_ok) begin
            intr_d = 1'b1;
        end else if (i_intr_clr) begin
            intr_d = 1'b0;
        end
        if (reject || stray_done) begin
            err_d[0] = 1'b1;
        end else if (i_err_clr) begin
            err_d[0] = 1'b0;
        end
        if (rel_tmo) begin
            err_d[1] = 1'b1;
        end else if (i_err_clr) begin
            err_d[1] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            proc_q  <= '0;
            occ_q   <= '0;
            run_q   <= '0;
            intr_q  <= 1'b0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            proc_q  <= proc_d;
            occ_q   <= occ_d;
            run_q   <= run_d;
            intr_q  <= intr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sauria_buf_ctrl.sv
// Bench for sauria_buf_ctrl: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_sauria_buf_ctrl;

    localparam int N  = 3;
    localparam int T  = 4;
    localparam int CW = 4;

    logic       clk = 1'b0;
    logic       rst, host_done, core_en, core_done, intr_clr, err_clr;
    logic       host_ready, core_start, intr;
    logic [1:0] host_sel, core_sel, err;
    logic [2:0] occ;
    logic [3:0] job_cnt;

    int total = 0;
    int bad   = 0;

    // model: buffers, pointers, and age of the in-flight job
    // (age -1 none, 0 start cycle, k>=1 k-th run cycle)
    int       m_fill, m_proc, m_occ, m_age, m_cnt;
    bit       m_intr;
    bit [1:0] m_err;

    always #5 clk = ~clk;

    sauria_buf_ctrl #(.NUM_BUF(N), .CNT_W(CW), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_host_done(host_done), .o_host_ready(host_ready), .o_host_sel(host_sel),
        .i_core_en(core_en), .o_core_start(core_start), .o_core_sel(core_sel),
        .i_core_done(core_done), .i_intr_clr(intr_clr), .i_err_clr(err_clr),
        .o_doneintr(intr), .o_err(err), .o_occ(occ), .o_job_cnt(job_cnt)
    );

    task automatic model_step();
        bit acc, rej, rel, tmo, stray;
        if (rst) begin
            m_fill = 0; m_proc = 0; m_occ = 0; m_age = -1;
            m_cnt = 0; m_intr = 0; m_err = 0;
            return;
        end
        acc   = host_done && (m_occ < N);
        rej   = host_done && !(m_occ < N);
        rel   = (m_age >= 1) && core_done;
        tmo   = (m_age >= 1) && !core_done && (m_age == T);
        stray = (m_age <= 0) && core_done;
        if (m_age == -1) m_age = (core_en && m_occ > 0) ? 0 : -1;
        else if (rel || tmo) m_age = -1;
        else m_age++;
        m_occ = m_occ + int'(acc) - int'(rel || tmo);
        if (acc) m_fill = (m_fill + 1) % N;
        if (rel || tmo) m_proc = (m_proc + 1) % N;
        m_intr   = rel ? 1'b1 : (intr_clr ? 1'b0 : m_intr);
        m_err[0] = (rej || stray) ? 1'b1 : (err_clr ? 1'b0 : m_err[0]);
        m_err[1] = tmo ? 1'b1 : (err_clr ? 1'b0 : m_err[1]);
        if (rel) m_cnt = (m_cnt + 1) % (1 << CW);
    endtask

    task automatic tick(input bit hd, en, cd, ic, ec, r);
        host_done = hd; core_en = en; core_done = cd;
        intr_clr = ic; err_clr = ec; rst = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0, 1);
        total++; if (host_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0d exp=1", host_ready); end
        total++; if (host_sel !== 2'd0) begin bad++; $display("FAIL rst_hsel got=%0d exp=0", host_sel); end
        total++; if (core_sel !== 2'd0) begin bad++; $display("FAIL rst_csel got=%0d exp=0", core_sel); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%0d exp=0", core_start); end
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occ); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL rst_intr got=%0d exp=0", intr); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL rst_err got=%0d exp=0", err); end
        total++; if (job_cnt !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", job_cnt); end
    endtask

    task automatic test_basic_job();
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        total++; if (occ !== 3'd1) begin bad++; $display("FAIL basic_occ1 got=%0d exp=1", occ); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL basic_early got=%0d exp=0", core_start); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%0d exp=1", core_start); end
        total++; if (core_sel !== 2'd0) begin bad++; $display("FAIL basic_sel got=%0d exp=0", core_sel); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%0d exp=0", core_start); end
        tick(0, 1, 1, 0, 0, 0);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL basic_intr got=%0d exp=1", intr); end
        total++; if (job_cnt !== 4'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", job_cnt); end
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL basic_occ0 got=%0d exp=0", occ); end
    endtask

    task automatic test_fill_full();
        tick(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) tick(1, 0, 0, 0, 0, 0);
        total++; if (occ !== 3'(N)) begin bad++; $display("FAIL full_occ got=%0d exp=%0d", occ, N); end
        total++; if (host_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0d exp=0", host_ready); end
        tick(1, 0, 0, 0, 0, 0);
        total++; if (err !== 2'b01) begin bad++; $display("FAIL full_err got=%0d exp=1", err); end
        total++; if (occ !== 3'(N)) begin bad++; $display("FAIL full_occ_hold got=%0d exp=%0d", occ, N); end
        total++; if (host_sel !== 2'd0) begin bad++; $display("FAIL full_hsel got=%0d exp=0", host_sel); end
        tick(0, 0, 0, 0, 1, 0);
        total++; if (err !== 2'b00) begin bad++; $display("FAIL full_errclr got=%0d exp=0", err); end
    endtask

    task automatic test_wrap_simul();
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            total++; if (occ !== 3'd1) begin bad++; $display("FAIL wrap_occ k=%0d got=%0d exp=1", k, occ); end
            total++; if (job_cnt !== 4'(k + 1)) begin bad++; $display("FAIL wrap_cnt got=%0d exp=%0d", job_cnt, k + 1); end
            total++; if (core_sel !== 2'((k + 1) % N)) begin bad++; $display("FAIL wrap_csel got=%0d exp=%0d", core_sel, (k + 1) % N); end
            total++; if (host_sel !== 2'((k + 2) % N)) begin bad++; $display("FAIL wrap_hsel got=%0d exp=%0d", host_sel, (k + 2) % N); end
            tick(0, 1, 0, 0, 0, 0);
            tick(0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic test_watchdog();
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL wd_start got=%0d exp=1", core_start); end
        for (int i = 0; i < T; i++) tick(0, 1, 0, 0, 0, 0);
        total++; if (occ !== 3'd1) begin bad++; $display("FAIL wd_early_occ got=%0d exp=1", occ); end
        total++; if (err !== 2'b00) begin bad++; $display("FAIL wd_early_err got=%0d exp=0", err); end
        tick(0, 1, 0, 0, 0, 0);
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL wd_occ got=%0d exp=0", occ); end
        total++; if (err !== 2'b10) begin bad++; $display("FAIL wd_err got=%0d exp=2", err); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL wd_intr got=%0d exp=0", intr); end
        total++; if (job_cnt !== 4'd0) begin bad++; $display("FAIL wd_cnt got=%0d exp=0", job_cnt); end
    endtask

    task automatic test_priority();
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 1, 0, 0);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL prio_intr got=%0d exp=1", intr); end
        tick(0, 1, 0, 1, 0, 0);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL prio_intrclr got=%0d exp=0", intr); end
        tick(0, 1, 1, 0, 0, 0);
        total++; if (err !== 2'b01) begin bad++; $display("FAIL prio_stray got=%0d exp=1", err); end
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL prio_occ got=%0d exp=0", occ); end
        tick(0, 1, 1, 0, 1, 0);
        total++; if (err !== 2'b01) begin bad++; $display("FAIL prio_errset got=%0d exp=1", err); end
        tick(0, 1, 0, 0, 1, 0);
        total++; if (err !== 2'b00) begin bad++; $display("FAIL prio_errclr got=%0d exp=0", err); end
    endtask

    task automatic test_reset_midrun();
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        total++; if (occ !== 3'd2) begin bad++; $display("FAIL mid_occ got=%0d exp=2", occ); end
        tick(0, 1, 0, 0, 0, 1);
        total++; if (occ !== 3'd0) begin bad++; $display("FAIL mid_rst_occ got=%0d exp=0", occ); end
        total++; if (host_sel !== 2'd0) begin bad++; $display("FAIL mid_rst_hsel got=%0d exp=0", host_sel); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL mid_rst_intr got=%0d exp=0", intr); end
        total++; if (job_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d exp=0", job_cnt); end
        total++; if (core_start !== 1'b0) begin bad++; $display("FAIL mid_rst_start got=%0d exp=0", core_start); end
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        total++; if (core_start !== 1'b1) begin bad++; $display("FAIL mid_restart got=%0d exp=1", core_start); end
        total++; if (core_sel !== 2'd0) begin bad++; $display("FAIL mid_restart_sel got=%0d exp=0", core_sel); end
    endtask

    task automatic test_random();
        tick(0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3000; c++) begin
            tick($urandom_range(0, 1) == 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 249) == 0);
            total++; if (host_ready !== (m_occ < N)) begin bad++; $display("FAIL rnd_ready c=%0d got=%0d exp=%0d", c, host_ready, m_occ < N); end
            total++; if (host_sel !== 2'(m_fill)) begin bad++; $display("FAIL rnd_hsel c=%0d got=%0d exp=%0d", c, host_sel, m_fill); end
            total++; if (core_sel !== 2'(m_proc)) begin bad++; $display("FAIL rnd_csel c=%0d got=%0d exp=%0d", c, core_sel, m_proc); end
            total++; if (core_start !== (m_age == 0)) begin bad++; $display("FAIL rnd_start c=%0d got=%0d exp=%0d", c, core_start, m_age == 0); end
            total++; if (occ !== 3'(m_occ)) begin bad++; $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, occ, m_occ); end
            total++; if (intr !== m_intr) begin bad++; $display("FAIL rnd_intr c=%0d got=%0d exp=%0d", c, intr, m_intr); end
            total++; if (err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d got=%0d exp=%0d", c, err, m_err); end
            total++; if (job_cnt !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, job_cnt, m_cnt); end
        end
    endtask

    initial begin
        rst = 1'b1; host_done = 1'b0; core_en = 1'b0;
        core_done = 1'b0; intr_clr = 1'b0; err_clr = 1'b0;
        m_fill = 0; m_proc = 0; m_occ = 0; m_age = -1;
        m_cnt = 0; m_intr = 0; m_err = 0;
        @(negedge clk);
        test_reset();
        test_basic_job();
        test_fill_full();
        test_wrap_simul();
        test_watchdog();
        test_priority();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sauria_buf_ctrl.md
SAURIA_BUF_CTRL -- requirements
Module: sauria_buf_ctrl

Interface
REQ-001 SHALL have parameter NUM_BUF, default 2: number of ping-pong SRAM buffer sets; legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-job counter.
REQ-003 SHALL have parameter TIMEOUT, default 0: maximum RUN cycles before abort; 0 disables the watchdog.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(NUM_BUF)).
REQ-005 Ports:
- i_clk, input, 1: single clock. All logic is on its rising edge.
- i_rst, input, 1: synchronous, active-high reset.
- i_host_done, input, 1: one-cycle pulse; host finished filling buffer o_host_sel.
- o_host_ready, output, 1: a free buffer is available for filling.
- o_host_sel, output, SEL_W: index of the buffer the host fills next.
- i_core_en, input, 1: core is allowed to start jobs.
- o_core_start, output, 1: one-cycle pulse launching a job on o_core_sel.
- o_core_sel, output, SEL_W: index of the buffer the core is using.
- i_core_done, input, 1: one-cycle pulse; core finished the current job.
- i_intr_clr, input, 1: clears o_doneintr.
- i_err_clr, input, 1: clears o_err.
- o_doneintr, output, 1: sticky completion interrupt.
- o_err, output, 2: sticky error flags. Bit 0 = protocol error; bit 1 = timeout.
- o_occ, output, SEL_W+1: number of buffers currently filled and not yet released.
- o_job_cnt, output, CNT_W: count of completed jobs.

Function
REQ-006 SHALL keep fill_ptr, proc_ptr (0..NUM_BUF-1) and occ (0..NUM_BUF). Both pointers wrap from NUM_BUF-1 to 0.
REQ-007 o_host_ready SHALL be (occ < NUM_BUF). o_host_sel SHALL equal fill_ptr.
REQ-008 When i_host_done && o_host_ready: fill_ptr advances by one and occ increments on the next edge.
REQ-009 When i_host_done && !o_host_ready: the pulse is ignored and o_err[0] is set.
REQ-010 Core FSM SHALL have states IDLE, START, RUN.
REQ-011 pend SHALL be occ minus 1 when the FSM is in START or RUN, else occ.
REQ-012 IDLE -> START when i_core_en && pend > 0.
REQ-013 START SHALL assert o_core_start for exactly one cycle, then go to RUN unconditionally.
REQ-014 RUN -> IDLE on i_core_done. On that transition (release): proc_ptr advances, occ decrements, o_job_cnt increments (wrapping modulo 2^CNT_W), and o_doneintr is set.
REQ-015 o_core_sel SHALL equal proc_ptr in every state.
REQ-016 i_core_done in IDLE or START SHALL be ignored and set o_err[0].
REQ-017 Simultaneous accepted i_host_done and release: occ is unchanged and both pointers advance.
REQ-018 Release then start latency: after release the FSM is in IDLE for one cycle. If pend > 0 and i_core_en is high, o_core_start pulses 2 cycles after the i_core_done edge.
REQ-019 Fill then start latency: with the FSM idle, o_core_start pulses 2 cycles after an accepted i_host_done with i_core_en high.
REQ-020 Deasserting i_core_en SHALL only block IDLE -> START; a job already in START or RUN proceeds.
REQ-021 If TIMEOUT != 0, a run counter SHALL clear on entry to RUN and increment each RUN cycle.
REQ-022 When the run counter reaches TIMEOUT without i_core_done, the FSM performs a release but sets o_err[1] instead of o_doneintr, and o_job_cnt is not incremented.
REQ-023 o_doneintr: set has priority over i_intr_clr in the same cycle.
REQ-024 o_err bits: set has priority over i_err_clr in the same cycle.
REQ-025 occ SHALL never exceed NUM_BUF nor underflow below 0.

Reset
REQ-026 On i_rst high at a clock edge, regardless of FSM state: fill_ptr=0, proc_ptr=0, occ=0, run counter=0, FSM=IDLE.
REQ-027 Reset output values: o_core_start=0, o_doneintr=0, o_err=0, o_job_cnt=0, o_host_ready=1, o_host_sel=0, o_core_sel=0, o_occ=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the job with no interrupt and no count update.

Verification
REQ-029 Basic job (NUM_BUF=2, core_en=1): host_done at cycle 0 -> o_core_start at cycle 2 with sel=0; core_done -> o_doneintr=1, o_job_cnt=1, occ=0.
REQ-030 Fill to full (NUM_BUF=2, core_en=0): 2 host_done -> occ=2, o_host_ready=0; a 3rd host_done -> o_err=2'b01, occ stays 2, fill_ptr=0.
REQ-031 Wrap and simultaneity (NUM_BUF=3): 5 jobs with host_done coincident with core_done -> pointers wrap 2->0, occ constant, o_job_cnt=5.
REQ-032 Watchdog (TIMEOUT=4): start a job with no core_done -> release after 4 RUN cycles, o_err=2'b10, o_doneintr=0, o_job_cnt=0.
REQ-033 Priority: i_intr_clr coincident with a release -> o_doneintr=1; stray core_done in IDLE -> o_err[0]=1, occ unchanged.
REQ-034 Reset mid-RUN with occ=2 -> next cycle all outputs at reset values; a subsequent host_done restarts cleanly with sel=0.
